// File: rtl/inv_shift_rows_stage.sv
// AES decryption stage: InvShiftRows with an optional round-key XOR, registered
// into a 2-entry skid buffer behind a valid/ready handshake.
module inv_shift_rows_stage #(
  parameter int ADD_KEY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [127:0]     in_key,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic             out_last,
  output logic [CNT_W-1:0] blk_cnt
);

  // Byte s[r][c] sits at bits [127-8*(4c+r) -: 8]; output s'[r][c] = s[r][(c-r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c-rw+4)%4)+rw) -: 8];
      end
    end
    return r;
  endfunction

  logic [128:0]     ent0_q, ent0_d;
  logic [128:0]     ent1_q, ent1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic [127:0]     xform;
  logic [128:0]     new_ent;
  logic             accept;
  logic             pop;

  assign in_ready  = rdy_q && !flush;
  assign out_valid = (cnt_q != 2'd0);
  assign out_state = ent0_q[127:0];
  assign out_last  = ent0_q[128];
  assign blk_cnt   = blk_q;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_comb begin
    xform = inv_shift_rows(in_state);
    if (ADD_KEY != 0) xform = xform ^ in_key;
    new_ent = {in_last, xform};
  end

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    blk_d  = blk_q + (accept ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}});
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_d = new_ent;
          else               ent1_d = new_ent;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          // Head slot keeps its stale value when the buffer drains empty.
          if (cnt_q == 2'd2) ent0_d = ent1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_d = new_ent;
          end else begin
            ent0_d = ent1_q;
            ent1_d = new_ent;
          end
        end
        default: ;
      endcase
    end
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b0;
      blk_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
      blk_q  <= blk_d;
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// Scoreboard bench for inv_shift_rows_stage: one keyed (CNT_W=16) and one
// unkeyed (CNT_W=4) instance share the same stimulus.
module tb_inv_shift_rows_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_state = '0;
  logic [127:0] in_key = '0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;

  logic         in_ready_k, out_valid_k, out_last_k;
  logic [127:0] out_state_k;
  logic [15:0]  blk_cnt_k;
  logic         in_ready_n, out_valid_n, out_last_n;
  logic [127:0] out_state_n;
  logic [3:0]   blk_cnt_n;

  always #5 clk = ~clk;

  inv_shift_rows_stage #(.ADD_KEY(1), .CNT_W(16)) u_key (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_k),
    .in_state(in_state), .in_key(in_key), .in_last(in_last),
    .out_valid(out_valid_k), .out_ready(out_ready),
    .out_state(out_state_k), .out_last(out_last_k), .blk_cnt(blk_cnt_k));

  inv_shift_rows_stage #(.ADD_KEY(0), .CNT_W(4)) u_nokey (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_n),
    .in_state(in_state), .in_key(in_key), .in_last(in_last),
    .out_valid(out_valid_n), .out_ready(out_ready),
    .out_state(out_state_n), .out_last(out_last_n), .blk_cnt(blk_cnt_n));

  typedef struct {
    logic [127:0] n;
    logic [127:0] k;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   exp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference transform written forward: row r of column c lands in column (c+r) mod 4.
  function automatic logic [127:0] m_isr(input logic [127:0] s);
    logic [7:0]   b[16];
    logic [7:0]   o[16];
    logic [127:0] r;
    for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
    for (int rw = 0; rw < 4; rw++)
      for (int c = 0; c < 4; c++) o[4*((c+rw)%4)+rw] = b[4*c+rw];
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = o[k];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid_k && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {127'd0, out_valid_k}, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_state_key", out_state_k, e.k);
        chk("out_state_nokey", out_state_n, e.n);
        chk("out_last", {127'd0, out_last_k}, {127'd0, e.last});
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send_exp(input logic [127:0] st, input logic [127:0] key, input logic last,
                          input logic [127:0] en, input logic [127:0] ek);
    exp_t e;
    bit ok;
    in_valid = 1'b1;
    in_state = st;
    in_key   = key;
    in_last  = last;
    ok = 1'b0;
    for (int w = 0; w < 50 && !ok; w++) begin
      @(negedge clk);
      if (in_ready_k) ok = 1'b1;
    end
    if (!ok) begin
      chk("send_timeout", 128'd0, 128'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.n = en;
    e.k = ek;
    e.last = last;
    sb.push_back(e);
    exp_cnt++;
  endtask

  task automatic send(input logic [127:0] st, input logic [127:0] key, input logic last);
    send_exp(st, key, last, m_isr(st), m_isr(st) ^ key);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] vec(input int i);
    return 128'h00112233_44556677_8899aabb_ccddeeff ^ {16{8'(i * 37 + 1)}};
  endfunction

  localparam logic [127:0] ST_A  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] KEY_A = 128'hffffffff_00000000_ffffffff_00000000;
  localparam logic [127:0] ST_B  = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int p0;
    #1;
    chk("rst_out_valid", {127'd0, out_valid_k}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready_k}, 128'd0);
    chk("rst_out_state", out_state_k, 128'd0);
    chk("rst_out_last", {127'd0, out_last_k}, 128'd0);
    chk("rst_blk_cnt", {112'd0, blk_cnt_k}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_in_ready", {127'd0, in_ready_k}, 128'd1);
    @(posedge clk);
    #1;

    // Transform and key XOR with hand-computed results.
    out_ready = 1'b1;
    send_exp(ST_A, KEY_A, 1'b0,
             128'h00ddaa77_4411eebb_885522ff_cc996633,
             128'hff225588_4411eebb_77aadd00_cc996633);
    in_valid = 1'b0;
    @(negedge clk);
    chk("first_out_valid", {127'd0, out_valid_k}, 128'd1);
    repeat (2) @(negedge clk);
    chk("transform_drained", 128'(sb.size()), 128'd0);

    // Backpressure: two blocks fill the buffer, head holds stable.
    do_reset();
    out_ready = 1'b0;
    send(ST_A, KEY_A, 1'b0);
    send(ST_B, 128'h01020304_05060708_090a0b0c_0d0e0f10, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", {127'd0, in_ready_k}, 128'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_state", out_state_k, m_isr(ST_A) ^ KEY_A);
    end
    pop_cyc.delete();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("in_ready_after_pop", {127'd0, in_ready_k}, 128'd1);
    #1;
    chk("bp_pops", 128'(pop_cyc.size()), 128'd2);
    if (pop_cyc.size() == 2) chk("bp_consecutive", 128'(pop_cyc[1] - pop_cyc[0]), 128'd1);

    // Streaming: eight back-to-back blocks, last marker on the eighth.
    do_reset();
    out_ready = 1'b1;
    pop_cyc.delete();
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(vec(i), {4{32'(i * 3 + 5)}}, i == 7);
    chk("stream_accept_cycles", 128'(cyc - t0), 128'd8);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("stream_pops", 128'(pop_cyc.size()), 128'd8);
    if (pop_cyc.size() == 8) chk("stream_consecutive", 128'(pop_cyc[7] - pop_cyc[0]), 128'd7);
    chk("stream_blk_cnt", {112'd0, blk_cnt_k}, 128'd8);
    chk("stream_blk_cnt_w4", {124'd0, blk_cnt_n}, 128'd8);

    // Flush with two buffered blocks and a competing input.
    do_reset();
    out_ready = 1'b0;
    send(vec(20), '0, 1'b0);
    send(vec(21), '0, 1'b0);
    flush = 1'b1;
    in_state = vec(22);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", {127'd0, out_valid_k}, 128'd0);
    chk("flush_blk_cnt", {112'd0, blk_cnt_k}, 128'd2);
    chk("flush_in_ready", {127'd0, in_ready_k}, 128'd1);
    @(posedge clk);
    #1;
    send(vec(23), '0, 1'b0);
    flush = 1'b1;
    in_state = vec(24);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush1_out_valid", {127'd0, out_valid_k}, 128'd0);
    chk("flush1_blk_cnt", {112'd0, blk_cnt_k}, 128'd3);

    // Asynchronous reset with one block buffered.
    do_reset();
    out_ready = 1'b0;
    send(vec(30), '0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", {127'd0, out_valid_k}, 128'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {127'd0, out_valid_k}, 128'd0);
    chk("async_rst_blk_cnt", {112'd0, blk_cnt_k}, 128'd0);
    chk("async_rst_in_ready", {127'd0, in_ready_k}, 128'd0);
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {127'd0, in_ready_k}, 128'd1);
    @(posedge clk);
    #1;

    // Counter wrap on the 4-bit instance.
    out_ready = 1'b1;
    p0 = exp_cnt;
    for (int i = 0; i < 17; i++) send(vec(40 + i), {4{32'(i)}}, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wrap_blk_cnt_w4", {124'd0, blk_cnt_n}, 128'(4'((exp_cnt - p0) % 16)));
    chk("wrap_blk_cnt_w16", {112'd0, blk_cnt_k}, 128'd17);
    chk("wrap_drained", 128'(sb.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
